// File: rtl/mii_nibble_packer.sv
// MII receive nibble packer: validates preamble/SFD, strips it and packs
// payload nibbles LSB-first into OUT_W-bit words with frame end reporting.
module mii_nibble_packer #(
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned PRE_MIN = 10,
  parameter int unsigned MAX_NIB = 3036,
  parameter int unsigned LEN_W   = 12
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [3:0]                       datain,
  input  logic                             ena,
  output logic [OUT_W-1:0]                 dataout,
  output logic                             dval,
  output logic [$clog2(OUT_W/4+1)-1:0]     dcnt,
  output logic                             sof,
  output logic                             eof,
  output logic [LEN_W-1:0]                 frame_len,
  output logic                             error_pzdc,
  output logic                             err_long,
  output logic                             err_align
);

  localparam int unsigned K       = OUT_W / 4;
  localparam int unsigned CW      = $clog2(K + 1);
  localparam int unsigned IW      = $clog2(K);
  localparam int unsigned NW      = $clog2(MAX_NIB + 2);
  localparam int unsigned LCW     = (NW > LEN_W) ? NW : LEN_W;
  localparam int unsigned LEN_MAX = (2 ** LEN_W) - 1;

  typedef enum logic [1:0] {StIdle, StPre, StData, StDrop} state_t;

  state_t           r_state, w_state;
  logic             r_ena;
  logic [3:0]       r_din;
  logic [3:0]       r_pre_cnt, w_pre_cnt;
  logic [IW-1:0]    r_nib_idx, w_nib_idx;
  logic [LCW-1:0]   r_len, w_len;
  logic             r_first, w_first;
  logic [OUT_W-1:0] r_acc, w_acc;

  logic [OUT_W-1:0] r_dataout, w_dataout;
  logic             r_dval, w_dval;
  logic [CW-1:0]    r_dcnt, w_dcnt;
  logic             r_sof, w_sof;
  logic             r_eof, w_eof;
  logic [LEN_W-1:0] r_frame_len, w_frame_len;
  logic             r_pzdc, w_pzdc;
  logic             r_long, w_long;
  logic             r_align, w_align;

  // Input stage: register RX_DV and the nibble before the FSM looks at them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ena <= 1'b0;
      r_din <= 4'h0;
    end else begin
      r_ena <= ena;
      r_din <= datain;
    end
  end

  // Next-state and registered-output computation from the sampled nibble.
  always_comb begin
    w_state     = r_state;
    w_pre_cnt   = r_pre_cnt;
    w_nib_idx   = r_nib_idx;
    w_len       = r_len;
    w_first     = r_first;
    w_acc       = r_acc;
    w_dataout   = '0;
    w_dval      = 1'b0;
    w_dcnt      = '0;
    w_sof       = 1'b0;
    w_eof       = 1'b0;
    w_frame_len = '0;
    w_pzdc      = 1'b0;
    w_long      = 1'b0;
    w_align     = 1'b0;
    case (r_state)
      StIdle: begin
        if (r_ena) begin
          if (r_din == 4'h5) begin
            w_state   = StPre;
            w_pre_cnt = 4'd1;
          end else begin
            w_pzdc  = 1'b1;
            w_state = StDrop;
          end
        end
      end
      StPre: begin
        if (!r_ena) begin
          w_pzdc  = 1'b1;
          w_state = StIdle;
        end else if (r_din == 4'h5) begin
          w_pre_cnt = (r_pre_cnt == 4'hf) ? 4'hf : r_pre_cnt + 1'b1;
        end else if (r_din == 4'hd && 32'(r_pre_cnt) >= PRE_MIN) begin
          w_state   = StData;
          w_nib_idx = '0;
          w_len     = '0;
          w_first   = 1'b1;
          w_acc     = '0;
        end else begin
          w_pzdc  = 1'b1;
          w_state = StDrop;
        end
      end
      StData: begin
        if (r_ena) begin
          w_len = r_len + 1'b1;
          if (r_len == LCW'(MAX_NIB)) begin
            // One nibble too many: abandon the frame silently apart from the pulse.
            w_long  = 1'b1;
            w_state = StDrop;
          end else begin
            w_acc[{r_nib_idx, 2'b00} +: 4] = r_din;
            if (r_nib_idx == IW'(K - 1)) begin
              w_dval    = 1'b1;
              w_dataout = w_acc;
              w_dcnt    = CW'(K);
              w_sof     = r_first;
              w_first   = 1'b0;
              w_nib_idx = '0;
              w_acc     = '0;
            end else begin
              w_nib_idx = r_nib_idx + 1'b1;
            end
          end
        end else begin
          w_eof       = 1'b1;
          w_frame_len = (r_len > LCW'(LEN_MAX)) ? LEN_W'(LEN_MAX) : LEN_W'(r_len);
          w_align     = r_len[0];
          // Upper nibbles of the accumulator are still zero from the last clear.
          if (r_nib_idx != '0) begin
            w_dval    = 1'b1;
            w_dataout = r_acc;
            w_dcnt    = CW'(r_nib_idx);
            w_sof     = r_first;
          end
          w_acc   = '0;
          w_state = StIdle;
        end
      end
      StDrop: begin
        if (!r_ena) begin
          w_state = StIdle;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  // State, counters, accumulator and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_pre_cnt   <= 4'h0;
      r_nib_idx   <= '0;
      r_len       <= '0;
      r_first     <= 1'b0;
      r_acc       <= '0;
      r_dataout   <= '0;
      r_dval      <= 1'b0;
      r_dcnt      <= '0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_frame_len <= '0;
      r_pzdc      <= 1'b0;
      r_long      <= 1'b0;
      r_align     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_pre_cnt   <= w_pre_cnt;
      r_nib_idx   <= w_nib_idx;
      r_len       <= w_len;
      r_first     <= w_first;
      r_acc       <= w_acc;
      r_dataout   <= w_dataout;
      r_dval      <= w_dval;
      r_dcnt      <= w_dcnt;
      r_sof       <= w_sof;
      r_eof       <= w_eof;
      r_frame_len <= w_frame_len;
      r_pzdc      <= w_pzdc;
      r_long      <= w_long;
      r_align     <= w_align;
    end
  end

  assign dataout    = r_dataout;
  assign dval       = r_dval;
  assign dcnt       = r_dcnt;
  assign sof        = r_sof;
  assign eof        = r_eof;
  assign frame_len  = r_frame_len;
  assign error_pzdc = r_pzdc;
  assign err_long   = r_long;
  assign err_align  = r_align;

endmodule

// File: tb/tb_mii_nibble_packer.sv
// Bench for mii_nibble_packer: three instances (8-bit, 32-bit, 8-bit with a
// short MAX_NIB) checked against a scoreboard of expected words and frame ends.
module tb_mii_nibble_packer;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  cnt;
    logic        sof;
    logic        eof;
  } word_t;

  typedef struct packed {
    logic [15:0] len;
    logic        align;
  } eof_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] din [3];
  logic       ena [3];

  logic [7:0]  o0_dout;  logic [1:0] o0_dcnt;  logic [11:0] o0_len;
  logic [31:0] o1_dout;  logic [3:0] o1_dcnt;  logic [11:0] o1_len;
  logic [7:0]  o2_dout;  logic [1:0] o2_dcnt;  logic [11:0] o2_len;
  logic o0_dval, o0_sof, o0_eof, o0_pz, o0_long, o0_al;
  logic o1_dval, o1_sof, o1_eof, o1_pz, o1_long, o1_al;
  logic o2_dval, o2_sof, o2_eof, o2_pz, o2_long, o2_al;

  word_t      wq [3][$];
  eof_t       eq [3][$];
  logic [3:0] pay [$];
  int         pz_cnt [3];
  int         long_cnt [3];
  int         n_err;
  int         n_checks;

  always #5 clock = ~clock;

  mii_nibble_packer #(.OUT_W(8), .PRE_MIN(10), .MAX_NIB(3036), .LEN_W(12)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .datain(din[0]), .ena(ena[0]),
    .dataout(o0_dout), .dval(o0_dval), .dcnt(o0_dcnt), .sof(o0_sof), .eof(o0_eof),
    .frame_len(o0_len), .error_pzdc(o0_pz), .err_long(o0_long), .err_align(o0_al)
  );

  mii_nibble_packer #(.OUT_W(32), .PRE_MIN(10), .MAX_NIB(3036), .LEN_W(12)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .datain(din[1]), .ena(ena[1]),
    .dataout(o1_dout), .dval(o1_dval), .dcnt(o1_dcnt), .sof(o1_sof), .eof(o1_eof),
    .frame_len(o1_len), .error_pzdc(o1_pz), .err_long(o1_long), .err_align(o1_al)
  );

  mii_nibble_packer #(.OUT_W(8), .PRE_MIN(10), .MAX_NIB(8), .LEN_W(12)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .datain(din[2]), .ena(ena[2]),
    .dataout(o2_dout), .dval(o2_dval), .dcnt(o2_dcnt), .sof(o2_sof), .eof(o2_eof),
    .frame_len(o2_len), .error_pzdc(o2_pz), .err_long(o2_long), .err_align(o2_al)
  );

  // Advance to the next falling edge and retire whatever the DUTs produced.
  task automatic step();
    logic [63:0] s_dout [3];
    int          s_cnt [3];
    int          s_len [3];
    logic        s_dval [3], s_sof [3], s_eof [3], s_pz [3], s_long [3], s_al [3];
    word_t       w;
    eof_t        e;
    @(negedge clock);
    s_dout = '{64'(o0_dout), 64'(o1_dout), 64'(o2_dout)};
    s_cnt  = '{int'(o0_dcnt), int'(o1_dcnt), int'(o2_dcnt)};
    s_len  = '{int'(o0_len), int'(o1_len), int'(o2_len)};
    s_dval = '{o0_dval, o1_dval, o2_dval};
    s_sof  = '{o0_sof, o1_sof, o2_sof};
    s_eof  = '{o0_eof, o1_eof, o2_eof};
    s_pz   = '{o0_pz, o1_pz, o2_pz};
    s_long = '{o0_long, o1_long, o2_long};
    s_al   = '{o0_al, o1_al, o2_al};
    for (int i = 0; i < 3; i++) begin
      if (s_pz[i]) pz_cnt[i]++;
      if (s_long[i]) long_cnt[i]++;
      if (s_dval[i]) begin
        n_checks++;
        if (wq[i].size() == 0) begin
          n_err++;
          $display("FAIL word dut%0d: unexpected dval dataout=%h, required no dval", i, s_dout[i]);
        end else begin
          w = wq[i].pop_front();
          if (s_dout[i] !== w.data || s_cnt[i] != int'(w.cnt) || s_sof[i] !== w.sof ||
              s_eof[i] !== w.eof) begin
            n_err++;
            $display("FAIL word dut%0d: dataout=%h dcnt=%0d sof=%b eof=%b, required %h/%0d/%b/%b",
                     i, s_dout[i], s_cnt[i], s_sof[i], s_eof[i], w.data, w.cnt, w.sof, w.eof);
          end
        end
      end
      if (s_eof[i]) begin
        n_checks++;
        if (eq[i].size() == 0) begin
          n_err++;
          $display("FAIL eof dut%0d: unexpected eof frame_len=%0d, required no eof", i, s_len[i]);
        end else begin
          e = eq[i].pop_front();
          if (s_len[i] != int'(e.len) || s_al[i] !== e.align) begin
            n_err++;
            $display("FAIL eof dut%0d: frame_len=%0d err_align=%b, required %0d/%b",
                     i, s_len[i], s_al[i], e.len, e.align);
          end
        end
      end else if (s_al[i]) begin
        n_checks++;
        n_err++;
        $display("FAIL align dut%0d: err_align=1 without eof, required 0", i);
      end
    end
  endtask

  // Drive preamble, SFD and the nibbles in pay with ena held high.
  task automatic send_body(input int i, input int npre, input logic [3:0] sfd);
    for (int k = 0; k < npre; k++) begin
      ena[i] = 1'b1;
      din[i] = 4'h5;
      step();
    end
    ena[i] = 1'b1;
    din[i] = sfd;
    step();
    foreach (pay[k]) begin
      din[i] = pay[k];
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ena[i] = 1'b0;
      din[i] = 4'h0;
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if ({o0_dval, o0_sof, o0_eof, o0_pz, o0_long, o0_al, o0_dout, o0_dcnt, o0_len} !== '0) begin
      n_err++;
      $display("FAIL reset dut0: outputs=%h/%b/%b/%0d, required all 0", o0_dout, o0_dval, o0_eof,
               o0_len);
    end
    n_checks++;
    if ({o1_dval, o1_sof, o1_eof, o1_pz, o1_long, o1_al, o1_dout, o1_dcnt, o1_len} !== '0) begin
      n_err++;
      $display("FAIL reset dut1: outputs=%h/%b/%b/%0d, required all 0", o1_dout, o1_dval, o1_eof,
               o1_len);
    end
    n_checks++;
    if ({o2_dval, o2_sof, o2_eof, o2_pz, o2_long, o2_al, o2_dout, o2_dcnt, o2_len} !== '0) begin
      n_err++;
      $display("FAIL reset dut2: outputs=%h/%b/%b/%0d, required all 0", o2_dout, o2_dval, o2_eof,
               o2_len);
    end
    reset_n = 1'b1;
    step();
  endtask

  // 15x5, D, 1,2,3,4: two full words then a clean frame end.
  task automatic run_basic_frame(input int i);
    int p0, l0;
    p0 = pz_cnt[i];
    l0 = long_cnt[i];
    wq[i].push_back(word_t'{64'h21, 8'd2, 1'b1, 1'b0});
    wq[i].push_back(word_t'{64'h43, 8'd2, 1'b0, 1'b0});
    eq[i].push_back(eof_t'{16'd4, 1'b0});
    pay = '{4'h1, 4'h2, 4'h3, 4'h4};
    send_body(i, 15, 4'hd);
    ena[i] = 1'b0;
    repeat (6) step();
    n_checks++;
    if (wq[i].size() != 0 || eq[i].size() != 0 || pz_cnt[i] != p0 || long_cnt[i] != l0) begin
      n_err++;
      $display("FAIL basic dut%0d: pending words=%0d eofs=%0d pz=%0d long=%0d, required 0",
               i, wq[i].size(), eq[i].size(), pz_cnt[i] - p0, long_cnt[i] - l0);
    end
  endtask

  task automatic test_basic();
    wq[0].push_back(word_t'{64'h21, 8'd2, 1'b1, 1'b0});
    wq[0].push_back(word_t'{64'h43, 8'd2, 1'b0, 1'b0});
    eq[0].push_back(eof_t'{16'd4, 1'b0});
    pay = '{4'h1, 4'h2, 4'h3, 4'h4};
    send_body(0, 15, 4'hd);
    ena[0] = 1'b0;
    step();
    n_checks++;
    if (o0_dval !== 1'b1 || o0_eof !== 1'b0) begin
      n_err++;
      $display("FAIL latency_word: dval=%b eof=%b, required 1/0", o0_dval, o0_eof);
    end
    step();
    n_checks++;
    if (o0_eof !== 1'b1 || o0_dval !== 1'b0) begin
      n_err++;
      $display("FAIL latency_eof: eof=%b dval=%b, required 1/0", o0_eof, o0_dval);
    end
    repeat (4) step();
    n_checks++;
    if (wq[0].size() != 0 || eq[0].size() != 0) begin
      n_err++;
      $display("FAIL basic: pending words=%0d eofs=%0d, required 0", wq[0].size(), eq[0].size());
    end
  endtask

  task automatic test_wide();
    wq[1].push_back(word_t'{64'h0065_4321, 8'd6, 1'b1, 1'b1});
    eq[1].push_back(eof_t'{16'd6, 1'b0});
    pay = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    send_body(1, 10, 4'hd);
    ena[1] = 1'b0;
    step();
    // Empty payload: frame end with length 0 and no word.
    eq[1].push_back(eof_t'{16'd0, 1'b0});
    pay = {};
    send_body(1, 12, 4'hd);
    ena[1] = 1'b0;
    repeat (6) step();
    n_checks++;
    if (wq[1].size() != 0 || eq[1].size() != 0) begin
      n_err++;
      $display("FAIL wide: pending words=%0d eofs=%0d, required 0", wq[1].size(), eq[1].size());
    end
  endtask

  task automatic test_pre_short();
    int p0;
    p0 = pz_cnt[0];
    pay = {};
    send_body(0, 7, 4'hd);
    ena[0] = 1'b0;
    repeat (4) step();
    n_checks++;
    if (pz_cnt[0] - p0 != 1) begin
      n_err++;
      $display("FAIL pre7: error_pzdc pulses=%0d, required 1", pz_cnt[0] - p0);
    end
    p0 = pz_cnt[0];
    pay = '{4'h1};
    send_body(0, 9, 4'hd);
    ena[0] = 1'b0;
    repeat (4) step();
    n_checks++;
    if (pz_cnt[0] - p0 != 1) begin
      n_err++;
      $display("FAIL pre9: error_pzdc pulses=%0d, required 1", pz_cnt[0] - p0);
    end
    run_basic_frame(0);
  endtask

  task automatic test_align();
    wq[0].push_back(word_t'{64'hba, 8'd2, 1'b1, 1'b0});
    wq[0].push_back(word_t'{64'h0c, 8'd1, 1'b0, 1'b1});
    eq[0].push_back(eof_t'{16'd3, 1'b1});
    pay = '{4'ha, 4'hb, 4'hc};
    send_body(0, 20, 4'hd);
    ena[0] = 1'b0;
    repeat (6) step();
    n_checks++;
    if (wq[0].size() != 0 || eq[0].size() != 0) begin
      n_err++;
      $display("FAIL align: pending words=%0d eofs=%0d, required 0", wq[0].size(), eq[0].size());
    end
  endtask

  task automatic test_long();
    int l0;
    l0 = long_cnt[2];
    wq[2].push_back(word_t'{64'h21, 8'd2, 1'b1, 1'b0});
    wq[2].push_back(word_t'{64'h43, 8'd2, 1'b0, 1'b0});
    wq[2].push_back(word_t'{64'h65, 8'd2, 1'b0, 1'b0});
    wq[2].push_back(word_t'{64'h87, 8'd2, 1'b0, 1'b0});
    pay = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'ha};
    send_body(2, 15, 4'hd);
    ena[2] = 1'b0;
    repeat (6) step();
    n_checks++;
    if (long_cnt[2] - l0 != 1 || wq[2].size() != 0) begin
      n_err++;
      $display("FAIL long: err_long pulses=%0d pending words=%0d, required 1/0",
               long_cnt[2] - l0, wq[2].size());
    end
    run_basic_frame(2);
  endtask

  task automatic test_reset_mid();
    wq[0].push_back(word_t'{64'h21, 8'd2, 1'b1, 1'b0});
    pay = '{4'h1, 4'h2};
    send_body(0, 15, 4'hd);
    din[0] = 4'h3;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (o0_dval !== 1'b0 || o0_dout !== 8'h00 || o0_sof !== 1'b0 || o0_eof !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: dval=%b dataout=%h sof=%b eof=%b, required 0/00/0/0",
               o0_dval, o0_dout, o0_sof, o0_eof);
    end
    ena[0] = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (6) step();
    n_checks++;
    if (wq[0].size() != 0 || eq[0].size() != 0) begin
      n_err++;
      $display("FAIL reset_mid drain: pending words=%0d eofs=%0d, required 0",
               wq[0].size(), eq[0].size());
    end
    run_basic_frame(0);
  endtask

  task automatic test_back_to_back();
    wq[0].push_back(word_t'{64'h21, 8'd2, 1'b1, 1'b0});
    eq[0].push_back(eof_t'{16'd2, 1'b0});
    wq[0].push_back(word_t'{64'h43, 8'd2, 1'b1, 1'b0});
    wq[0].push_back(word_t'{64'h05, 8'd1, 1'b0, 1'b1});
    eq[0].push_back(eof_t'{16'd3, 1'b1});
    pay = '{4'h1, 4'h2};
    send_body(0, 10, 4'hd);
    ena[0] = 1'b0;
    step();
    pay = '{4'h3, 4'h4, 4'h5};
    send_body(0, 10, 4'hd);
    ena[0] = 1'b0;
    repeat (6) step();
    n_checks++;
    if (wq[0].size() != 0 || eq[0].size() != 0) begin
      n_err++;
      $display("FAIL back_to_back: pending words=%0d eofs=%0d, required 0",
               wq[0].size(), eq[0].size());
    end
  endtask

  initial begin
    n_err    = 0;
    n_checks = 0;
    for (int i = 0; i < 3; i++) begin
      pz_cnt[i]   = 0;
      long_cnt[i] = 0;
    end
    test_reset();
    test_basic();
    test_wide();
    test_pre_short();
    test_align();
    test_long();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
